// File: rtl/vedic_mul_seq.sv
// rtl/vedic_mul_seq.sv - sequential WIDTHxWIDTH unsigned multiplier sharing one 4x4 Vedic core
// Digit pairs are issued one per cycle; each product is shifted into a 2*WIDTH accumulator.

module vedic2x2 (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [3:0] p_o
);
   logic cross_a, cross_b, carry1, hi;

   always_comb begin
      cross_a = a_i[1] & b_i[0];
      cross_b = a_i[0] & b_i[1];
      carry1  = cross_a & cross_b;
      hi      = a_i[1] & b_i[1];
      p_o[0]  = a_i[0] & b_i[0];
      p_o[1]  = cross_a ^ cross_b;
      p_o[2]  = hi ^ carry1;
      p_o[3]  = hi & carry1;
   end
endmodule

module vedic4X4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);
   logic [3:0] q0, q1, q2, q3;
   logic [4:0] mid_sum;
   logic [5:0] upper_sum;

   vedic2x2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0));
   vedic2x2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1));
   vedic2x2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2));
   vedic2x2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3));

   // Product >> 2 never exceeds 56, so a 6-bit upper sum cannot overflow.
   always_comb begin
      mid_sum   = {1'b0, q1} + {1'b0, q2};
      upper_sum = {1'b0, mid_sum} + {q3, q0[3:2]};
      p_o       = {upper_sum, q0[1:0]};
   end
endmodule

module vedic_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);
   localparam int K  = WIDTH / 4;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam int AW = 2 * WIDTH;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t          state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]   i_q, j_q;
   logic [AW-1:0]   acc_q, acc_d;
   logic [AW-1:0]   out_product_q;
   logic            in_ready_q, out_valid_q, busy_q;

   logic [3:0]      a_dig, b_dig;
   logic [7:0]      pp;
   logic [IW:0]     digit_pos;
   logic [AW-1:0]   pp_shifted;

   always_comb begin
      a_dig = a_q[{i_q, 2'b00} +: 4];
      b_dig = b_q[{j_q, 2'b00} +: 4];
   end

   vedic4X4 u_core (.a_i(a_dig), .b_i(b_dig), .p_o(pp));

   always_comb begin
      digit_pos  = {1'b0, i_q} + {1'b0, j_q};
      pp_shifted = {{(AW-8){1'b0}}, pp} << {digit_pos, 2'b00};
      acc_d      = acc_q + pp_shifted;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         i_q           <= '0;
         j_q           <= '0;
         acc_q         <= '0;
         out_product_q <= '0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  acc_q      <= '0;
                  i_q        <= '0;
                  j_q        <= '0;
                  state_q    <= MUL;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            MUL: begin
               acc_q <= acc_d;
               if (j_q == LAST) begin
                  j_q <= '0;
                  if (i_q == LAST) begin
                     i_q           <= '0;
                     state_q       <= DONE;
                     out_valid_q   <= 1'b1;
                     out_product_q <= acc_d;
                  end else begin
                     i_q <= i_q + IW'(1);
                  end
               end else begin
                  j_q <= j_q + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready    = in_ready_q;
      out_valid   = out_valid_q;
      busy        = busy_q;
      out_product = out_product_q;
   end
endmodule

// File: tb/tb_vedic_mul_seq.sv
// tb/tb_vedic_mul_seq.sv - directed and random checks of vedic_mul_seq at WIDTH 8 and 16

module tb_vedic_mul_seq;
   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vedic_mul_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_a(a8), .in_b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_product(p8), .busy(busy8)
   );

   vedic_mul_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_a(a16), .in_b(b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_product(p16), .busy(busy16)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec8_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic accept8(input logic [7:0] a, input logic [7:0] b);
      for (int c = 0; c < 64 && !in_ready8; c++) @(negedge clk);
      in_valid8 = 1'b1;
      a8 = a;
      b8 = b;
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   task automatic wait_out8(output int lat);
      lat = 0;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (out_valid8) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic accept16(input logic [15:0] a, input logic [15:0] b);
      for (int c = 0; c < 64 && !in_ready16; c++) @(negedge clk);
      in_valid16 = 1'b1;
      a16 = a;
      b16 = b;
      @(negedge clk);
      in_valid16 = 1'b0;
   endtask

   task automatic wait_out16(output int lat);
      lat = 0;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (out_valid16) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      vec8_t vecs[10];
      int    lat;
      logic  seen;
      logic [15:0] ra, rb;
      logic [31:0] rexp;
      int    stall;

      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[1] = '{8'h00, 8'hAB, 16'h0000};
      vecs[2] = '{8'h0C, 8'h0D, 16'h009C};
      vecs[3] = '{8'h01, 8'h01, 16'h0001};
      vecs[4] = '{8'h10, 8'h10, 16'h0100};
      vecs[5] = '{8'h80, 8'h02, 16'h0100};
      vecs[6] = '{8'h0F, 8'hF0, 16'h0E10};
      vecs[7] = '{8'h12, 8'h34, 16'h03A8};
      vecs[8] = '{8'hA5, 8'h5A, 16'h3A02};
      vecs[9] = '{8'hFF, 8'h01, 16'h00FF};

      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", {63'd0, in_ready8}, 64'd1);
      chk("reset out_valid", {63'd0, out_valid8}, 64'd0);
      chk("reset busy", {63'd0, busy8}, 64'd0);
      chk("reset product", {48'd0, p8}, 64'd0);
      chk("reset in_ready16", {63'd0, in_ready16}, 64'd1);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         accept8(vecs[v].a, vecs[v].b);
         chk("busy after accept", {63'd0, busy8}, 64'd1);
         wait_out8(lat);
         chk("latency w8", 64'(lat), 64'd4);
         chk("product w8", {48'd0, p8}, {48'd0, vecs[v].prod});
         out_ready8 = 1'b1;
         @(negedge clk);
         out_ready8 = 1'b0;
         chk("idle after handshake", {62'd0, in_ready8, out_valid8}, 64'b10);
         chk("product kept in idle", {48'd0, p8}, {48'd0, vecs[v].prod});
      end

      // backpressure: result held for 10 stalled cycles
      accept8(8'h3A, 8'hB7);
      wait_out8(lat);
      chk("bp latency", 64'(lat), 64'd4);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp held", {45'd0, out_valid8, in_ready8, p8}, {45'd0, 1'b1, 1'b0, 16'h2976});
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      chk("bp release", {62'd0, in_ready8, out_valid8}, 64'b10);

      // operands presented during MUL are ignored; accepted on the first IDLE cycle
      accept8(8'h12, 8'h34);
      in_valid8 = 1'b1;
      a8 = 8'hFF;
      b8 = 8'hFF;
      wait_out8(lat);
      chk("ignore latency", 64'(lat), 64'd4);
      chk("ignore product", {48'd0, p8}, 64'h03A8);
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("ignore idle", {63'd0, in_ready8}, 64'd1);
      @(negedge clk);
      in_valid8 = 1'b0;
      chk("second accepted", {63'd0, busy8}, 64'd1);
      wait_out8(lat);
      chk("second latency", 64'(lat), 64'd4);
      chk("second product", {48'd0, p8}, 64'hFE01);
      @(negedge clk);
      out_ready8 = 1'b0;

      // reset during MUL cycle 2
      accept8(8'hFF, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort state", {45'd0, in_ready8, out_valid8, busy8, p8}, {45'd0, 3'b100, 16'h0000});
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         seen = seen | out_valid8;
      end
      chk("no spurious out_valid", {63'd0, seen}, 64'd0);

      // reset wins over in_valid
      rst = 1'b1;
      in_valid8 = 1'b1;
      a8 = 8'h03;
      b8 = 8'h03;
      @(negedge clk);
      rst = 1'b0;
      in_valid8 = 1'b0;
      chk("rst beats in_valid", {62'd0, busy8, in_ready8}, 64'b01);
      @(negedge clk);
      chk("still idle", {63'd0, busy8}, 64'd0);

      // WIDTH=16 corner
      out_ready16 = 1'b0;
      accept16(16'hFFFF, 16'hFFFF);
      wait_out16(lat);
      chk("latency w16", 64'(lat), 64'd16);
      chk("product w16 max", {32'd0, p16}, 64'hFFFE0001);
      out_ready16 = 1'b1;
      @(negedge clk);
      out_ready16 = 1'b0;

      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         rexp = 32'(ra) * 32'(rb);
         stall = $urandom_range(0, 3);
         accept16(ra, rb);
         wait_out16(lat);
         chk("rand latency", 64'(lat), 64'd16);
         repeat (stall) @(negedge clk);
         chk("rand product", {31'd0, out_valid16, p16}, {31'd0, 1'b1, rexp});
         out_ready16 = 1'b1;
         @(negedge clk);
         out_ready16 = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
